// File: rtl/control_pipeline_pkg.sv
// Shared widths, encodings and per-stage control bundles for the MIPS control pipeline.
package control_pipeline_pkg;

  localparam int unsigned CP_REG_AW  = 5;
  localparam int unsigned CP_ALUOP_W = 2;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned OPCODE_W   = 6;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [CP_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [CP_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [CP_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2b;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;

  // Control bits still needed once an instruction reaches EX.
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  function automatic mem_ctrl_t to_mem_ctrl(input ex_ctrl_t c);
    mem_ctrl_t m;
    m.mem_to_reg = c.mem_to_reg;
    m.reg_write  = c.reg_write;
    m.mem_read   = c.mem_read;
    m.mem_write  = c.mem_write;
    m.branch     = c.branch;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t c);
    wb_ctrl_t w;
    w.mem_to_reg = c.mem_to_reg;
    w.reg_write  = c.reg_write;
    return w;
  endfunction

endpackage

// File: rtl/control_pipeline_forward_unit.sv
// EX-stage operand forwarding selects; EX/MEM result takes priority over MEM/WB.
module forward_unit
  import control_pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = CP_REG_AW
) (
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_mem_write_reg,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_write_reg,
  output logic [FWD_W-1:0]  o_forward_a_c,
  output logic [FWD_W-1:0]  o_forward_b_c
);

  logic w_mem_src_ok;
  logic w_wb_src_ok;

  // $0 is hard-wired zero, so a write to it is never a forwarding source.
  assign w_mem_src_ok = i_mem_reg_write && (i_mem_write_reg != '0);
  assign w_wb_src_ok  = i_wb_reg_write  && (i_wb_write_reg  != '0);

  always_comb begin
    o_forward_a_c = FWD_RF;
    if (w_mem_src_ok && (i_mem_write_reg == i_ex_rs)) begin
      o_forward_a_c = FWD_MEM;
    end else if (w_wb_src_ok && (i_wb_write_reg == i_ex_rs)) begin
      o_forward_a_c = FWD_WB;
    end
  end

  always_comb begin
    o_forward_b_c = FWD_RF;
    if (w_mem_src_ok && (i_mem_write_reg == i_ex_rt)) begin
      o_forward_b_c = FWD_MEM;
    end else if (w_wb_src_ok && (i_wb_write_reg == i_ex_rt)) begin
      o_forward_b_c = FWD_WB;
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// Control path of a 5-stage MIPS pipeline: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, MEM-stage branch flush and EX forwarding selects.
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int unsigned REG_AW  = CP_REG_AW,
  parameter int unsigned ALUOP_W = CP_ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RegDst_in,
  input  logic               ALUSrc_in,
  input  logic               MemToReg_in,
  input  logic               RegWrite_in,
  input  logic               MemRead_in,
  input  logic               MemWrite_in,
  input  logic               Branch_in,
  input  logic [ALUOP_W-1:0] ALUOp_in,
  input  logic [REG_AW-1:0]  id_rs_in,
  input  logic [REG_AW-1:0]  id_rt_in,
  input  logic [REG_AW-1:0]  id_rd_in,
  input  logic               alu_zero_in,
  output logic               pc_write_out,
  output logic               ifid_write_out,
  output logic               ifid_flush_out,
  output logic               pcsrc_out,
  output logic               ex_RegDst_out,
  output logic               ex_ALUSrc_out,
  output logic [ALUOP_W-1:0] ex_ALUOp_out,
  output logic [1:0]         forward_a_out,
  output logic [1:0]         forward_b_out,
  output logic               mem_MemRead_out,
  output logic               mem_MemWrite_out,
  output logic               mem_Branch_out,
  output logic               wb_RegWrite_out,
  output logic               wb_MemToReg_out,
  output logic [REG_AW-1:0]  wb_write_reg_out
);

  ex_ctrl_t           w_id_ctrl;
  ex_ctrl_t           r_ex_ctrl;
  logic [ALUOP_W-1:0] r_ex_alu_op;
  logic [REG_AW-1:0]  r_ex_rs;
  logic [REG_AW-1:0]  r_ex_rt;
  logic [REG_AW-1:0]  r_ex_rd;
  logic [REG_AW-1:0]  w_ex_write_reg;

  mem_ctrl_t          r_mem_ctrl;
  logic [REG_AW-1:0]  r_mem_write_reg;

  wb_ctrl_t           r_wb_ctrl;
  logic [REG_AW-1:0]  r_wb_write_reg;

  logic               w_load_use;
  logic               w_pcsrc;
  logic               w_idex_bubble;
  logic [FWD_W-1:0]   w_forward_a;
  logic [FWD_W-1:0]   w_forward_b;

  assign w_id_ctrl.reg_dst    = RegDst_in;
  assign w_id_ctrl.alu_src    = ALUSrc_in;
  assign w_id_ctrl.mem_to_reg = MemToReg_in;
  assign w_id_ctrl.reg_write  = RegWrite_in;
  assign w_id_ctrl.mem_read   = MemRead_in;
  assign w_id_ctrl.mem_write  = MemWrite_in;
  assign w_id_ctrl.branch     = Branch_in;

  assign w_ex_write_reg = r_ex_ctrl.reg_dst ? r_ex_rd : r_ex_rt;

  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  assign w_load_use = r_ex_ctrl.mem_read && (r_ex_rt != '0) &&
                      ((r_ex_rt == id_rs_in) || (r_ex_rt == id_rt_in));

  assign w_pcsrc       = r_mem_ctrl.branch && alu_zero_in;
  assign w_idex_bubble = w_load_use || w_pcsrc;

  // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
  assign pc_write_out   = !(w_load_use && !w_pcsrc);
  assign ifid_write_out = !(w_load_use && !w_pcsrc);
  assign ifid_flush_out = w_pcsrc;
  assign pcsrc_out      = w_pcsrc;

  // Register fields advance even through a bubble; only control bits are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_ctrl       <= '0;
      r_ex_alu_op     <= '0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_rd         <= '0;
      r_mem_ctrl      <= '0;
      r_mem_write_reg <= '0;
      r_wb_ctrl       <= '0;
      r_wb_write_reg  <= '0;
    end else begin
      r_ex_ctrl       <= w_idex_bubble ? ex_ctrl_t'('0) : w_id_ctrl;
      r_ex_alu_op     <= w_idex_bubble ? ALUOP_W'(0) : ALUOp_in;
      r_ex_rs         <= id_rs_in;
      r_ex_rt         <= id_rt_in;
      r_ex_rd         <= id_rd_in;
      r_mem_ctrl      <= w_pcsrc ? mem_ctrl_t'('0) : to_mem_ctrl(r_ex_ctrl);
      r_mem_write_reg <= w_ex_write_reg;
      r_wb_ctrl       <= to_wb_ctrl(r_mem_ctrl);
      r_wb_write_reg  <= r_mem_write_reg;
    end
  end

  forward_unit #(
    .REG_AW (REG_AW)
  ) u_forward_unit (
    .i_ex_rs         (r_ex_rs),
    .i_ex_rt         (r_ex_rt),
    .i_mem_reg_write (r_mem_ctrl.reg_write),
    .i_mem_write_reg (r_mem_write_reg),
    .i_wb_reg_write  (r_wb_ctrl.reg_write),
    .i_wb_write_reg  (r_wb_write_reg),
    .o_forward_a_c   (w_forward_a),
    .o_forward_b_c   (w_forward_b)
  );

  assign forward_a_out    = w_forward_a;
  assign forward_b_out    = w_forward_b;

  assign ex_RegDst_out    = r_ex_ctrl.reg_dst;
  assign ex_ALUSrc_out    = r_ex_ctrl.alu_src;
  assign ex_ALUOp_out     = r_ex_alu_op;
  assign mem_MemRead_out  = r_mem_ctrl.mem_read;
  assign mem_MemWrite_out = r_mem_ctrl.mem_write;
  assign mem_Branch_out   = r_mem_ctrl.branch;
  assign wb_RegWrite_out  = r_wb_ctrl.reg_write;
  assign wb_MemToReg_out  = r_wb_ctrl.mem_to_reg;
  assign wb_write_reg_out = r_wb_write_reg;

endmodule
